// File: rtl/arbitro_rr_multiclase.sv
// ---------------------------------------------------------------------------------------------
// arbitro_rr_multiclase
//
// Multi-input class router. Selects one word per cycle from NUM_IN first-word-fall-through
// input FIFOs and forwards it to one of NUM_OUT = 2**CLASS_W output FIFOs. The output FIFO is
// chosen by the word's class field, which is its top CLASS_W bits. The arbitration mode is
// chosen at runtime: round-robin, or fixed priority with input 0 highest. An input is skipped
// when its destination FIFO is almost full; the other inputs are still served. A saturating
// transfer counter is kept for each output.
//
// Ports
//   clk                 clock
//   reset               synchronous reset, active low
//   data_in_i           head word of each input FIFO; slice i = [i*WORD_SIZE +: WORD_SIZE]
//   fifo_empty_i        empty flag per input FIFO
//   fifos_almost_full_i almost-full flag per output FIFO
//   prio_mode_i         0 = round-robin, 1 = fixed priority (input 0 highest)
//   cnt_clear_i         synchronous clear of all transfer counters
//   data_out_o          registered word to the output FIFOs
//   pop_o               one-hot pop to the input FIFOs (combinational)
//   push_o              one-hot push to the output FIFOs (registered)
//   cuenta_o            per-output transfer counters; slice j = [j*CNT_W +: CNT_W]
//   idle_o              registered; high when nothing was granted and all inputs were empty
// ---------------------------------------------------------------------------------------------
module arbitro_rr_multiclase #(
   parameter int unsigned WORD_SIZE = 12,
   parameter int unsigned NUM_IN    = 4,
   parameter int unsigned CLASS_W   = 2,
   parameter int unsigned CNT_W     = 5,
   localparam int unsigned NUM_OUT  = 2 ** CLASS_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_IN*WORD_SIZE-1:0] data_in_i,
   input  logic [NUM_IN-1:0]           fifo_empty_i,
   input  logic [NUM_OUT-1:0]          fifos_almost_full_i,
   input  logic                        prio_mode_i,
   input  logic                        cnt_clear_i,
   output logic [WORD_SIZE-1:0]        data_out_o,
   output logic [NUM_IN-1:0]           pop_o,
   output logic [NUM_OUT-1:0]          push_o,
   output logic [NUM_OUT*CNT_W-1:0]    cuenta_o,
   output logic                        idle_o
);

   localparam int unsigned PTR_W = $clog2(NUM_IN);
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   // ------------------------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------------------------
   logic [WORD_SIZE-1:0] data_out_q, data_out_d;
   logic [NUM_OUT-1:0]   push_q,     push_d;
   logic [PTR_W-1:0]     last_q,     last_d;
   logic                 idle_q,     idle_d;
   logic [CNT_W-1:0]     cnt_q [NUM_OUT];
   logic [CNT_W-1:0]     cnt_d [NUM_OUT];

   // ------------------------------------------------------------------------------------------
   // Per-input class and eligibility
   // ------------------------------------------------------------------------------------------
   logic [CLASS_W-1:0] cls [NUM_IN];
   logic [NUM_IN-1:0]  elig;

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         cls[i]  = data_in_i[i*WORD_SIZE + (WORD_SIZE - CLASS_W) +: CLASS_W];
         elig[i] = !fifo_empty_i[i] && !fifos_almost_full_i[cls[i]];
      end
   end

   // ------------------------------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------------------------------
   logic                 gnt_valid;
   logic [PTR_W-1:0]     gnt_idx;
   logic [CLASS_W-1:0]   gnt_cls;
   logic [WORD_SIZE-1:0] gnt_word;

   // Both scans run from the lowest to the highest precedence, so the last eligible hit
   // written is the winner.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (prio_mode_i) begin
         for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (elig[i]) begin
               gnt_valid = 1'b1;
               gnt_idx   = PTR_W'(i);
            end
         end
      end else begin
         // Round-robin scan order is last+1, last+2, ..., last+NUM_IN (mod NUM_IN).
         for (int k = NUM_IN; k >= 1; k--) begin
            if (elig[(int'(last_q) + k) % NUM_IN]) begin
               gnt_valid = 1'b1;
               gnt_idx   = PTR_W'((int'(last_q) + k) % NUM_IN);
            end
         end
      end
   end

   always_comb begin
      gnt_cls  = cls[gnt_idx];
      gnt_word = data_in_i[int'(gnt_idx)*WORD_SIZE +: WORD_SIZE];
   end

   // The pop is suppressed during reset so the input FIFOs never advance at a reset edge.
   always_comb begin
      pop_o = '0;
      if (reset && gnt_valid) begin
         pop_o = NUM_IN'(1) << gnt_idx;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      data_out_d = data_out_q;
      push_d     = '0;
      last_d     = last_q;
      if (gnt_valid) begin
         data_out_d = gnt_word;
         push_d     = NUM_OUT'(1) << gnt_cls;
         last_d     = gnt_idx;
      end
      idle_d = !gnt_valid && (&fifo_empty_i);
   end

   // The clear takes precedence over a same-cycle increment.
   always_comb begin
      for (int j = 0; j < NUM_OUT; j++) begin
         cnt_d[j] = cnt_q[j];
      end
      if (cnt_clear_i) begin
         for (int j = 0; j < NUM_OUT; j++) begin
            cnt_d[j] = '0;
         end
      end else if (gnt_valid && (cnt_q[gnt_cls] != CntMax)) begin
         cnt_d[gnt_cls] = cnt_q[gnt_cls] + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------------------------
   // last_q resets to NUM_IN-1 so the first round-robin search starts at input 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_out_q <= '0;
         push_q     <= '0;
         last_q     <= PTR_W'(NUM_IN - 1);
         idle_q     <= 1'b1;
         for (int j = 0; j < NUM_OUT; j++) begin
            cnt_q[j] <= '0;
         end
      end else begin
         data_out_q <= data_out_d;
         push_q     <= push_d;
         last_q     <= last_d;
         idle_q     <= idle_d;
         for (int j = 0; j < NUM_OUT; j++) begin
            cnt_q[j] <= cnt_d[j];
         end
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   always_comb begin
      data_out_o = data_out_q;
      push_o     = push_q;
      idle_o     = idle_q;
      for (int j = 0; j < NUM_OUT; j++) begin
         cuenta_o[j*CNT_W +: CNT_W] = cnt_q[j];
      end
   end

endmodule
